temp_avg_flt: RTL and testbench

Parametrised temperature smoothing filter between the ADT7420 I2C reader and the seven-segment/LED display path. It accepts signed fixed-point temperature samples (1/16 °C per LSB) over a valid/ready handshake. Per sample it produces either the raw value, a boxcar moving average over `DEPTH` samples, or a first-order exponential average. It replaces the fixed single-window filter and adds a runtime mode, depth, width and priming on first sample.

---
 rtl/temp_avg_flt_if.sv | 34 +++
 rtl/temp_avg_flt.sv | 173 +++++++++++++++++
 tb/tb_temp_avg_flt.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/temp_avg_flt_if.sv
// Sample handshake bundle between the ADT7420 reader and the temperature smoothing filter.
interface temp_avg_flt_if #(
   parameter int unsigned DATA_W = 13
) ();

   logic [1:0]               mode;
   logic                     in_valid;
   logic signed [DATA_W-1:0] in_data;
   logic                     in_ready;
   logic                     out_valid;
   logic signed [DATA_W-1:0] out_data;
   logic                     primed;

   modport master (
      output mode,
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  primed
   );

   modport slave (
      input  mode,
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_valid,
      output out_data,
      output primed
   );

endinterface

// File: rtl/temp_avg_flt.sv
// Temperature smoothing filter: bypass, DEPTH-sample boxcar or exponential average.
// Build option TEMP_FLT_ROUND_EN: round half up before the averaging shifts (default floor).
module temp_avg_flt #(
   parameter int unsigned DATA_W      = 13,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned ALPHA_SHIFT = 3
) (
   input logic           clk,
   input logic           rst_n,
   temp_avg_flt_if.slave bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned SUM_W = DATA_W + PTR_W;
   localparam int unsigned ACC_W = DATA_W + ALPHA_SHIFT;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

`ifdef TEMP_FLT_ROUND_EN
   localparam logic signed [SUM_W-1:0] BOX_RND = SUM_W'(2 ** (PTR_W - 1));
   localparam logic signed [ACC_W-1:0] EXP_RND = ACC_W'(2 ** (ALPHA_SHIFT - 1));
`else
   localparam logic signed [SUM_W-1:0] BOX_RND = '0;
   localparam logic signed [ACC_W-1:0] EXP_RND = '0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRIME,
      ST_CALC,
      ST_OUT
   } state_e;

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [PTR_W-1:0]         ptr_q, ptr_d;
   logic signed [SUM_W-1:0]  sum_q, sum_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [DATA_W-1:0] sample_q, sample_d;
   logic [1:0]               mode_q, mode_d;
   logic                     primed_q, primed_d;
   logic                     in_ready_q, in_ready_d;
   logic                     out_valid_q, out_valid_d;
   logic signed [DATA_W-1:0] out_data_q, out_data_d;

   logic signed [DATA_W-1:0] win_mem [DEPTH];
   logic                     win_we;
   logic [PTR_W-1:0]         win_addr;

   logic signed [SUM_W-1:0]  box_sum;
   logic signed [DATA_W-1:0] box_res;
   logic signed [ACC_W-1:0]  exp_acc;
   logic signed [DATA_W-1:0] exp_res;
   logic                     keep_prime;

   // Steady-state datapath for the sample currently held in sample_q
   always_comb begin
      box_sum = sum_q + SUM_W'(sample_q) - SUM_W'(win_mem[ptr_q]);
      box_res = DATA_W'((box_sum + BOX_RND) >>> PTR_W);
      exp_acc = acc_q + ACC_W'(sample_q) - (acc_q >>> ALPHA_SHIFT);
      exp_res = DATA_W'((exp_acc + EXP_RND) >>> ALPHA_SHIFT);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ptr_d       = ptr_q;
      sum_d       = sum_q;
      acc_d       = acc_q;
      sample_d    = sample_q;
      mode_d      = mode_q;
      primed_d    = primed_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      win_we      = 1'b0;
      win_addr    = ptr_q;
      keep_prime  = primed_q && (bus.mode == mode_q);

      unique case (state_q)
         ST_IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               sample_d = bus.in_data;
               mode_d   = bus.mode;
               primed_d = keep_prime;
               cnt_d    = '0;
               state_d  = (bus.mode == 2'd1 && !keep_prime) ? ST_PRIME : ST_CALC;
            end
         end
         // DEPTH fill writes, then one cycle to load the sum and publish the sample
         ST_PRIME: begin
            if (cnt_q == CNT_W'(DEPTH)) begin
               sum_d       = SUM_W'(sample_q) <<< PTR_W;
               ptr_d       = '0;
               out_data_d  = sample_q;
               out_valid_d = 1'b1;
               primed_d    = 1'b1;
               state_d     = ST_OUT;
            end else begin
               win_we   = 1'b1;
               win_addr = PTR_W'(cnt_q);
               cnt_d    = cnt_q + CNT_W'(1);
            end
         end
         ST_CALC: begin
            out_valid_d = 1'b1;
            primed_d    = 1'b1;
            state_d     = ST_OUT;
            unique case (mode_q)
               2'd1: begin
                  sum_d      = box_sum;
                  win_we     = 1'b1;
                  ptr_d      = ptr_q + PTR_W'(1);
                  out_data_d = box_res;
               end
               2'd2: begin
                  if (primed_q) begin
                     acc_d      = exp_acc;
                     out_data_d = exp_res;
                  end else begin
                     acc_d      = ACC_W'(sample_q) <<< ALPHA_SHIFT;
                     out_data_d = sample_q;
                  end
               end
               default: out_data_d = sample_q;
            endcase
         end
         ST_OUT: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      in_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         ptr_q       <= '0;
         sum_q       <= '0;
         acc_q       <= '0;
         sample_q    <= '0;
         mode_q      <= '0;
         primed_q    <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
         sum_q       <= sum_d;
         acc_q       <= acc_d;
         sample_q    <= sample_d;
         mode_q      <= mode_d;
         primed_q    <= primed_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   // Window storage is never reset; a cleared primed flag forces a refill
   always_ff @(posedge clk) begin
      if (win_we) begin
         win_mem[win_addr] <= sample_q;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.primed    = primed_q;

endmodule

// File: tb/tb_temp_avg_flt.sv
// Directed bench for temp_avg_flt with DEPTH = 4, ALPHA_SHIFT = 3.
module tb_temp_avg_flt;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   temp_avg_flt_if #(.DATA_W(13)) bus ();

   temp_avg_flt #(.DATA_W(13), .DEPTH(4), .ALPHA_SHIFT(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int                got_lat;
   int                got_rdy;
   int                got_vcnt;
   logic              got_early;
   logic              got_primed;
   logic signed [12:0] got_data;

   // Offer one sample at a negedge; record output latency, value and in_ready return
   task automatic send(input logic [1:0] m, input logic signed [12:0] d);
      int k;
      got_lat    = -1;
      got_rdy    = -1;
      got_vcnt   = 0;
      got_early  = 1'bx;
      got_primed = 1'bx;
      got_data   = 'x;
      k = 0;
      while (bus.in_ready !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      bus.mode     = m;
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int i = 1; i <= 50; i++) begin
         if (i > 1) @(negedge clk);
         if (i == 1) got_early = bus.primed;
         if (bus.out_valid === 1'b1) begin
            got_vcnt++;
            if (got_lat < 0) begin
               got_lat    = i;
               got_data   = bus.out_data;
               got_primed = bus.primed;
            end
         end
         if (bus.in_ready === 1'b1) begin
            got_rdy = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      bus.in_valid = 1'b1;
      bus.mode     = 2'd0;
      bus.in_data  = 13'sd100;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.primed !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold cyc%0d: valid=%b ready=%b primed=%b, want 0 0 0",
                     i, bus.out_valid, bus.in_ready, bus.primed);
         end
      end
      bus.in_valid = 1'b0;
      rst_n        = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_data !== 13'sd0) begin
         n_fail++;
         $display("FAIL reset_release: ready=%b data=%0d, want 1 0", bus.in_ready, bus.out_data);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle cyc%0d: valid=%b want 0", i, bus.out_valid);
         end
      end
   endtask

   task automatic test_bypass();
      logic [1:0]         m_tab [3] = '{2'd0, 2'd0, 2'd3};
      logic signed [12:0] d_tab [3] = '{13'sd328, -13'sd328, -13'sd5};
      for (int i = 0; i < 3; i++) begin
         send(m_tab[i], d_tab[i]);
         n_checks++;
         if (got_lat !== 2 || got_data !== d_tab[i] || got_primed !== 1'b1 ||
             got_vcnt !== 1 || got_rdy !== 3) begin
            n_fail++;
            $display("FAIL bypass[%0d]: lat=%0d data=%0d primed=%b vcnt=%0d rdy=%0d, want 2 %0d 1 1 3",
                     i, got_lat, got_data, got_primed, got_vcnt, got_rdy, d_tab[i]);
         end
      end
      @(negedge clk);
      n_checks++;
      if (bus.out_data !== -13'sd5 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bypass_hold: data=%0d valid=%b, want -5 0", bus.out_data, bus.out_valid);
      end
   endtask

   task automatic test_box_prime();
      send(2'd1, 13'sd320);
      n_checks++;
      if (got_lat !== 6 || got_data !== 13'sd320 || got_primed !== 1'b1 ||
          got_early !== 1'b0 || got_rdy !== 7 || got_vcnt !== 1) begin
         n_fail++;
         $display("FAIL box_prime: lat=%0d data=%0d primed=%b early=%b rdy=%0d vcnt=%0d, want 6 320 1 0 7 1",
                  got_lat, got_data, got_primed, got_early, got_rdy, got_vcnt);
      end
   endtask

   task automatic test_box_steady();
      logic signed [12:0] d_tab [5] = '{13'sd336, 13'sd352, 13'sd368, 13'sd384, 13'sd400};
      logic signed [12:0] e_tab [5] = '{13'sd324, 13'sd332, 13'sd344, 13'sd360, 13'sd376};
      for (int i = 0; i < 5; i++) begin
         send(2'd1, d_tab[i]);
         n_checks++;
         if (got_lat !== 2 || got_data !== e_tab[i] || got_primed !== 1'b1) begin
            n_fail++;
            $display("FAIL box_steady[%0d]: lat=%0d data=%0d primed=%b, want 2 %0d 1",
                     i, got_lat, got_data, got_primed, e_tab[i]);
         end
      end
   endtask

   task automatic test_box_negative();
      send(2'd0, 13'sd0);
      send(2'd1, -13'sd328);
      n_checks++;
      if (got_lat !== 6 || got_data !== -13'sd328) begin
         n_fail++;
         $display("FAIL neg_prime: lat=%0d data=%0d, want 6 -328", got_lat, got_data);
      end
      // sum -1311: floor(-327.75) and round-half-up(-327.75) both give -328
      send(2'd1, -13'sd327);
      n_checks++;
      if (got_lat !== 2 || got_data !== -13'sd328) begin
         n_fail++;
         $display("FAIL neg_step: lat=%0d data=%0d, want 2 -328", got_lat, got_data);
      end
   endtask

   task automatic test_exp_mode_change();
      send(2'd2, 13'sd0);
      n_checks++;
      if (got_lat !== 2 || got_data !== 13'sd0 || got_early !== 1'b0 || got_primed !== 1'b1) begin
         n_fail++;
         $display("FAIL exp_prime: lat=%0d data=%0d early=%b primed=%b, want 2 0 0 1",
                  got_lat, got_data, got_early, got_primed);
      end
      send(2'd2, 13'sd80);
      n_checks++;
      if (got_lat !== 2 || got_data !== 13'sd10) begin
         n_fail++;
         $display("FAIL exp_step: lat=%0d data=%0d, want 2 10", got_lat, got_data);
      end
      send(2'd1, 13'sd100);
      n_checks++;
      if (got_lat !== 6 || got_data !== 13'sd100 || got_early !== 1'b0 || got_primed !== 1'b1) begin
         n_fail++;
         $display("FAIL mode_change: lat=%0d data=%0d early=%b primed=%b, want 6 100 0 1",
                  got_lat, got_data, got_early, got_primed);
      end
   endtask

   // in_valid held high through the busy window: second sample is taken 3 cycles later
   task automatic test_back_to_back();
      bus.mode     = 2'd0;
      bus.in_data  = 13'sd50;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_data = 13'sd77;
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 13'sd50) begin
         n_fail++;
         $display("FAIL b2b_first: valid=%b data=%0d, want 1 50", bus.out_valid, bus.out_data);
      end
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_ready: ready=%b valid=%b, want 1 0", bus.in_ready, bus.out_valid);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 13'sd77) begin
         n_fail++;
         $display("FAIL b2b_second: valid=%b data=%0d, want 1 77", bus.out_valid, bus.out_data);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midop();
      bus.mode     = 2'd1;
      bus.in_data  = 13'sd200;
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.primed !== 1'b0) begin
         n_fail++;
         $display("FAIL midop_reset: ready=%b valid=%b primed=%b, want 0 0 0",
                  bus.in_ready, bus.out_valid, bus.primed);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_quiet cyc%0d: valid=%b ready=%b, want 0 1",
                     i, bus.out_valid, bus.in_ready);
         end
      end
      send(2'd1, 13'sd200);
      n_checks++;
      if (got_lat !== 6 || got_data !== 13'sd200) begin
         n_fail++;
         $display("FAIL midop_reprime: lat=%0d data=%0d, want 6 200", got_lat, got_data);
      end
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      bus.mode     = 2'd0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      test_reset();
      test_bypass();
      test_box_prime();
      test_box_steady();
      test_box_negative();
      test_exp_mode_change();
      test_back_to_back();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
